// File: rtl/trig_guard_pkg.sv
// Shared types and default constants for the trig_guard trigger counter-measure block.
package trig_guard_pkg;

  typedef enum logic [1:0] {
    PASS       = 2'b00,
    QUARANTINE = 2'b01,
    LOCKED     = 2'b10
  } state_t;

  localparam int DEF_DATA_W      = 128;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_THRESH = 4;

endpackage

// File: rtl/trig_guard_if.sv
// Valid/ready stream bundle around trig_guard: producer-side input and consumer-side output.
interface trig_guard_if
  import trig_guard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // master is the surrounding environment (AES core feeding in, consumer draining out)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/trig_guard_sync.sv
// trig_sync: multi-flop synchroniser for an asynchronous trigger line plus rising-edge
// detector; emits a single-cycle event pulse per low-to-high transition.
module trig_sync
  import trig_guard_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trig_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign event_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/trig_guard.sv
// trig_guard: registered valid/ready pass stage that scrubs and quarantines on trigger events,
// locking after LOCK_THRESH events. Optional TRIG_GUARD_TIMESTAMP_EN adds first-event timestamp.
module trig_guard
  import trig_guard_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  trig_guard_if.slave      bus,
  output logic             alarm,
  input  logic             alarm_clr,
  output logic [CNT_W-1:0] event_cnt,
  output logic [1:0]       state_o
`ifdef TRIG_GUARD_TIMESTAMP_EN
  ,
  output logic [31:0]      first_evt_ts,
  output logic             ts_valid
`endif
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(LOCK_THRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic evt;

  trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .trig_in (trig_in),
    .event_o (evt)
  );

  state_t            state_q, state_d, evt_state;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              alarm_q, alarm_d;
  logic              in_ready;

  // Outside PASS every beat is accepted and dropped so the producer never stalls on us.
  assign in_ready = (state_q != PASS) | ~out_valid_q | bus.out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    cnt_inc     = sat_inc(cnt_q);
    evt_state   = (cnt_inc >= THRESH) ? LOCKED : QUARANTINE;
    unique case (state_q)
      PASS: begin
        if (evt) begin
          state_d     = evt_state;
          cnt_d       = cnt_inc;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end else if (bus.in_valid && in_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      QUARANTINE: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        if (evt) begin
          state_d = evt_state;
          cnt_d   = cnt_inc;
        end else if (alarm_clr) begin
          state_d = PASS;
        end
      end
      LOCKED: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        if (evt) cnt_d = cnt_inc;
      end
      default: begin
        state_d     = LOCKED;
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    endcase
    alarm_d = (state_d != PASS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PASS;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign alarm         = alarm_q;
  assign event_cnt     = cnt_q;
  assign state_o       = state_q;

`ifdef TRIG_GUARD_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d, ts_q, ts_d;
  logic        ts_valid_q, ts_valid_d;

  always_comb begin
    cyc_d      = cyc_q + 32'd1;
    ts_d       = ts_q;
    ts_valid_d = ts_valid_q;
    if (evt && !ts_valid_q) begin
      ts_d       = cyc_q;
      ts_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      ts_q       <= ts_d;
      ts_valid_q <= ts_valid_d;
    end
  end

  assign first_evt_ts = ts_q;
  assign ts_valid     = ts_valid_q;
`endif

endmodule

// File: tb/tb_trig_guard.sv
// Directed bench for trig_guard: passthrough, backpressure, quarantine, lock and saturation.
module tb_trig_guard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       trig_a, trig_b, clr_a, clr_b, alarm_a, alarm_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] st_a, st_b;

  int checks   = 0;
  int failures = 0;

  trig_guard_if #(.DATA_W(128)) bus_a ();
  trig_guard_if #(.DATA_W(128)) bus_b ();

`ifdef TRIG_GUARD_TIMESTAMP_EN
  logic [31:0] ts_a, ts_b, tb_cyc, ts_exp;
  logic        tsv_a, tsv_b;
  always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;
`endif

  trig_guard #(.DATA_W(128), .SYNC_STAGES(2), .CNT_W(8), .LOCK_THRESH(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_a),
    .bus       (bus_a),
    .alarm     (alarm_a),
    .alarm_clr (clr_a),
    .event_cnt (cnt_a),
    .state_o   (st_a)
`ifdef TRIG_GUARD_TIMESTAMP_EN
    ,
    .first_evt_ts (ts_a),
    .ts_valid     (tsv_a)
`endif
  );

  trig_guard #(.DATA_W(128), .SYNC_STAGES(2), .CNT_W(2), .LOCK_THRESH(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_b),
    .bus       (bus_b),
    .alarm     (alarm_b),
    .alarm_clr (clr_b),
    .event_cnt (cnt_b),
    .state_o   (st_b)
`ifdef TRIG_GUARD_TIMESTAMP_EN
    ,
    .first_evt_ts (ts_b),
    .ts_valid     (tsv_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle trigger pulse; returns once its effect is visible on the outputs.
  task automatic pulse(input bit on_b);
    if (on_b) trig_b = 1'b1; else trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    trig_b = 1'b0;
    step();
    step();
  endtask

  logic [127:0] d_dead, d_beef, d_cafe;

  initial begin
    d_dead = {8{16'hDEAD}};
    d_beef = {8{16'hBEEF}};
    d_cafe = {8{16'hCAFE}};
    rst = 1'b1;
    trig_a = 1'b0; trig_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    step();
    step();
    chk("rst_state", st_a, 2'b00);
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_out_data", bus_a.out_data, '0);
    chk("rst_alarm", alarm_a, 1'b0);
    chk("rst_cnt", cnt_a, 8'd0);
    rst = 1'b0;

    // Passthrough: 8 beats, each appears one cycle after acceptance
    for (int i = 1; i <= 8; i++) begin
      bus_a.in_data  = 128'(i);
      bus_a.in_valid = 1'b1;
      step();
      chk("pass_valid", bus_a.out_valid, 1'b1);
      chk("pass_data", bus_a.out_data, 128'(i));
    end
    chk("pass_alarm", alarm_a, 1'b0);
    chk("pass_cnt", cnt_a, 8'd0);
    bus_a.in_valid = 1'b0;
    step();
    chk("pass_drain", bus_a.out_valid, 1'b0);

    // Backpressure
    bus_a.out_ready = 1'b0;
    bus_a.in_data   = d_dead;
    bus_a.in_valid  = 1'b1;
    step();
    chk("bp_load", bus_a.out_data, d_dead);
    bus_a.in_data = d_beef;
    repeat (5) begin
      step();
      chk("bp_hold_data", bus_a.out_data, d_dead);
      chk("bp_in_ready", bus_a.in_ready, 1'b0);
      chk("bp_hold_valid", bus_a.out_valid, 1'b1);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus_a.in_ready, 1'b1);
    step();
    chk("bp_delivered_once", bus_a.out_valid, 1'b0);
    step();
    chk("bp_no_dup", bus_a.out_valid, 1'b0);

    // Quarantine on a trigger during a stalled beat
    bus_a.out_ready = 1'b0;
    bus_a.in_data   = d_cafe;
    bus_a.in_valid  = 1'b1;
    step();
    chk("q_stalled", bus_a.out_data, d_cafe);
    bus_a.in_valid = 1'b0;
    trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    chk("q_lat1_state", st_a, 2'b00);
    chk("q_lat1_valid", bus_a.out_valid, 1'b1);
    step();
    chk("q_lat2_state", st_a, 2'b00);
    chk("q_lat2_data", bus_a.out_data, d_cafe);
    step();
    chk("q_valid", bus_a.out_valid, 1'b0);
    chk("q_data", bus_a.out_data, '0);
    chk("q_alarm", alarm_a, 1'b1);
    chk("q_state", st_a, 2'b01);
    chk("q_cnt", cnt_a, 8'd1);
    chk("q_in_ready", bus_a.in_ready, 1'b1);
    bus_a.in_data  = 128'h1234;
    bus_a.in_valid = 1'b1;
    step();
    chk("q_discard", bus_a.out_valid, 1'b0);
    bus_a.in_valid = 1'b0;

    // Event and alarm_clr in the same cycle: event wins
    trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    step();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("sim_state", st_a, 2'b01);
    chk("sim_cnt", cnt_a, 8'd2);
    chk("sim_alarm", alarm_a, 1'b1);

    // alarm_clr leaves quarantine, passthrough resumes
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("clr_state", st_a, 2'b00);
    chk("clr_alarm", alarm_a, 1'b0);
    bus_a.out_ready = 1'b1;
    bus_a.in_data   = 128'h55;
    bus_a.in_valid  = 1'b1;
    step();
    chk("resume_valid", bus_a.out_valid, 1'b1);
    chk("resume_data", bus_a.out_data, 128'h55);
    bus_a.in_valid = 1'b0;
    step();

    // Lock at the fourth event
    pulse(1'b0);
    chk("e3_state", st_a, 2'b01);
    chk("e3_cnt", cnt_a, 8'd3);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("e3_clr", st_a, 2'b00);
    pulse(1'b0);
    chk("lock_state", st_a, 2'b10);
    chk("lock_cnt", cnt_a, 8'd4);
    chk("lock_alarm", alarm_a, 1'b1);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("lock_clr_ignored", st_a, 2'b10);
    chk("lock_clr_alarm", alarm_a, 1'b1);
    bus_a.in_data  = 128'h77;
    bus_a.in_valid = 1'b1;
    step();
    chk("lock_discard", bus_a.out_valid, 1'b0);
    chk("lock_in_ready", bus_a.in_ready, 1'b1);
    bus_a.in_valid = 1'b0;
    pulse(1'b0);
    chk("lock_evt_cnt", cnt_a, 8'd5);
    chk("lock_evt_state", st_a, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rerst_state", st_a, 2'b00);
    chk("rerst_cnt", cnt_a, 8'd0);
    chk("rerst_alarm", alarm_a, 1'b0);
    chk("rerst_valid", bus_a.out_valid, 1'b0);

    // Level held high on the narrow-counter instance: one event only
    trig_b = 1'b1;
    step();
    step();
`ifdef TRIG_GUARD_TIMESTAMP_EN
    ts_exp = tb_cyc;
`endif
    repeat (98) step();
    chk("level_cnt", cnt_b, 2'd1);
    chk("level_state", st_b, 2'b01);
    trig_b = 1'b0;
    step();
    step();
    step();
    chk("level_fall_cnt", cnt_b, 2'd1);
    pulse(1'b1);
    chk("sat_cnt2", cnt_b, 2'd2);
    chk("sat_state2", st_b, 2'b01);
    pulse(1'b1);
    chk("sat_cnt3", cnt_b, 2'd3);
    chk("sat_lock", st_b, 2'b10);
    repeat (4) pulse(1'b1);
    chk("sat_nowrap", cnt_b, 2'd3);
    chk("sat_lock_hold", st_b, 2'b10);
`ifdef TRIG_GUARD_TIMESTAMP_EN
    chk("ts_value", ts_b, ts_exp);
    chk("ts_valid", tsv_b, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
